cordic_mul_arbiter: RTL and testbench
=====================================

# cordic_mul_arbiter

Round-robin arbiter that shares one iterative CORDIC multiplier (Q1.14, start/done handshake) among `NREQ` requesters. It captures the winning requester's operands, issues a single-cycle `mul_start`, waits for `mul_done`, and returns the product to the winning requester with a one-cycle valid pulse. It sits between the DSP clients (mixers, gain stages) and the shared multiplier instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WL`, 16: operand/result word length, Q1.14 signed.
- `TIMEOUT`, 64: watchdog limit in cycles; used only when `CORDIC_ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-requester request level.
- `in1_bus`, `in2_bus`  in  NREQ*WL  operands; requester k occupies bits `[k*WL +: WL]`.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured.
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: result ready for that requester.
- `rsp_data`  out  WL  product; valid only while `|rsp_valid`.
- `rsp_err`  out  1  watchdog expired; qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `mul_start`  out  1  one-cycle start to the multiplier.
- `mul_in1`, `mul_in2`  out  WL  multiplier operands, held from ISSUE until the next capture.
- `mul_out`  in  WL  multiplier result.
- `mul_done`  in  1  multiplier completion pulse.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `mul_start`=0, `mul_in1`=`mul_in2`=0, state=IDLE, priority pointer `ptr`=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if `|req`, select the first asserted request at or after `ptr` (cyclic search), latch its operands into `mul_in1`/`mul_in2`, record `owner`, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): `gnt[owner]`=1, `mul_start`=1. Go to WAIT.
  - WAIT: on `mul_done`=1, latch `mul_out` into `rsp_data` and go to RESP.
  - RESP (1 cycle): `rsp_valid[owner]`=1. Set `ptr`=(owner+1) mod NREQ. Go to IDLE.
- `req` is sampled only in IDLE. `mul_done` is ignored outside WAIT.
- Requester rules:
  - Hold `req` and operands stable until `gnt`.
  - Deassert `req` in the cycle after `gnt` unless another operation is wanted.
  - A `req` still high in IDLE after RESP is treated as a new request.
- Fairness: a requester waits at most NREQ-1 other operations.
- Results are pass-through; the arbiter does no rounding or saturation on `mul_out`.
- Reset mid-operation aborts the operation and returns everything to reset values. No response is produced, and requesters must re-request.

## Timing
- Minimum `req` to `gnt`: 1 cycle. Arbitration happens at the edge ending the first IDLE cycle in which `req` is seen, and `gnt` is high during the next cycle.
- `mul_start` and `gnt` are coincident.
- `rsp_valid` is high in the cycle after the cycle in which `mul_done` is sampled high.
- Back-to-back operations: at least 1 IDLE cycle separates RESP from the next ISSUE.
- Throughput: one operation per (multiplier latency + 3) cycles.
- Simultaneous requests: only one grant is issued; the others wait in order from `ptr`.

## Configuration
- `CORDIC_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - If the counter reaches `TIMEOUT` without `mul_done`, the FSM goes to RESP with `rsp_err`=1 and `rsp_data`=0.
  - A late `mul_done` arriving afterwards is ignored.
- `CORDIC_ARB_TIMEOUT_EN` not defined: no counter is built, `rsp_err` is tied to 0, and WAIT waits indefinitely.

## Structure
- Package `cordic_arb_pkg`: FSM state encoding, default `WL`/`NREQ`/`TIMEOUT` constants, and the Q1.14 constants used by benches (0.5 = 16'sh2000, 0.25 = 16'sh1000).
- Sub-module `cordic_rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs one-hot `pick` and `any`. Kept separate so it can be unit-tested exhaustively.

## Test plan
- Single requester: req[0] with 16'sh2000 × 16'sh2000 → `gnt[0]` one cycle after req; `rsp_valid[0]` with `rsp_data`=16'sh1000 ±2 LSB; `busy` low again after RESP.
- All four requesters assert simultaneously after reset → grants in order 0,1,2,3; each `rsp_valid[k]` precedes `gnt[k+1]`; no overlapping `gnt` or `rsp_valid`.
- Requester 2 served, then req[1] and req[3] both high → `gnt[3]` before `gnt[1]` (pointer = 3).
- Negative operands: 16'shE000 (−0.5) × 16'sh2000 → `rsp_data`=16'shF000 ±2 LSB, `rsp_err`=0.
- `rst_n` pulsed low during WAIT → all outputs 0 asynchronously; no `rsp_valid` afterwards; a new req[1] is served normally.
- With `CORDIC_ARB_TIMEOUT_EN` defined and `TIMEOUT`=64, hold `mul_done`=0 → `rsp_valid[owner]`=1, `rsp_err`=1, `rsp_data`=0 at 64 cycles in WAIT; a later `mul_done` pulse produces no response.

Source files
------------

// File: rtl/cordic_arb_pkg.sv
// cordic_arb_pkg: shared types and constants for the CORDIC multiplier arbiter.
// Holds FSM encoding, default sizing and Q1.14 reference constants.
package cordic_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_e;

  localparam int ARB_NREQ    = 4;
  localparam int ARB_WL      = 16;
  localparam int ARB_TIMEOUT = 64;

  localparam logic signed [15:0] Q_HALF    = 16'sh2000;
  localparam logic signed [15:0] Q_QUARTER = 16'sh1000;

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) oh2idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/cordic_rr_pick.sv
// cordic_rr_pick: combinational round-robin picker.
// Returns the first asserted request at or after ptr, one-hot.
module cordic_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  int          sum;
  logic [PW-1:0] idx;

  // Scan downward so the lowest offset from ptr wins last.
  always_comb begin
    pick = '0;
    sum  = 0;
    idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = PW'(sum);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/cordic_mul_arbiter.sv
// cordic_mul_arbiter: round-robin share of one iterative CORDIC multiplier.
// Optional WAIT watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_mul_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int NREQ    = ARB_NREQ,
  parameter int WL      = ARB_WL,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*WL-1:0] in1_bus,
  input  logic [NREQ*WL-1:0] in2_bus,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [WL-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_start,
  output logic [WL-1:0]      mul_in1,
  output logic [WL-1:0]      mul_in2,
  input  logic [WL-1:0]      mul_out,
  input  logic               mul_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [NREQ-1:0] own_oh_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rv_q;
  logic [WL-1:0]   data_q;
  logic            busy_q;
  logic            start_q;
  logic [WL-1:0]   in1_q;
  logic [WL-1:0]   in2_q;

  logic [NREQ-1:0] pick;
  logic            any;
  logic [PW-1:0]   pick_idx;
  logic [WL-1:0]   in1_d;
  logic [WL-1:0]   in2_d;
  logic [PW-1:0]   ptr_d;

  cordic_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  assign pick_idx = PW'(oh2idx(8'(pick)));
  assign in1_d    = in1_bus[pick_idx*WL +: WL];
  assign in2_d    = in2_bus[pick_idx*WL +: WL];
  assign ptr_d    = (owner_q == PW'(NREQ - 1)) ? '0
                                               : owner_q + PW'(1);

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign rsp_err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      own_oh_q <= '0;
      gnt_q    <= '0;
      rv_q     <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any) begin
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            owner_q  <= pick_idx;
            own_oh_q <= pick;
            gnt_q    <= pick;
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gnt_q   <= '0;
          start_q <= 1'b0;
          state_q <= S_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_done) begin
            data_q  <= mul_out;
            rv_q    <= own_oh_q;
            state_q <= S_RESP;
          end
`ifdef CORDIC_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            data_q  <= '0;
            err_q   <= 1'b1;
            rv_q    <= own_oh_q;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        S_RESP: begin
          rv_q    <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
`ifdef CORDIC_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = data_q;
  assign busy      = busy_q;
  assign mul_start = start_q;
  assign mul_in1   = in1_q;
  assign mul_in2   = in2_q;

endmodule

// File: tb/tb_cordic_mul_arbiter.sv
// tb_cordic_mul_arbiter: directed bench with a behavioural Q1.14 multiplier.
// Watchdog checks follow CORDIC_ARB_TIMEOUT_EN like the design.
module tb_cordic_mul_arbiter;
  import cordic_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int WL   = 16;
  localparam int TMO  = 64;
  localparam int LAT  = 5;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*WL-1:0] in1_bus;
  logic [NREQ*WL-1:0] in2_bus;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [WL-1:0]      rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               mul_start;
  logic [WL-1:0]      mul_in1;
  logic [WL-1:0]      mul_in2;
  logic [WL-1:0]      mul_out;
  logic               mul_done;

  cordic_mul_arbiter #(
    .NREQ    (NREQ),
    .WL      (WL),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in1_bus   (in1_bus),
    .in2_bus   (in2_bus),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_out   (mul_out),
    .mul_done  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: fixed latency, optional stall before done.
  function automatic logic [15:0] mulq(input logic [15:0] a,
                                       input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p >>> 14);
  endfunction

  logic        mul_stall;
  logic        m_act;
  int          m_cnt;
  logic [15:0] m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act    <= 1'b0;
      m_cnt    <= 0;
      m_prod   <= '0;
      mul_done <= 1'b0;
      mul_out  <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start && !m_act) begin
        m_act  <= 1'b1;
        m_cnt  <= LAT;
        m_prod <= mulq(mul_in1, mul_in2);
      end else if (m_act) begin
        if (m_cnt > 1) begin
          m_cnt <= m_cnt - 1;
        end else if (!mul_stall) begin
          mul_done <= 1'b1;
          mul_out  <= m_prod;
          m_act    <= 1'b0;
        end
      end
    end
  end

  int   v_oh = 0;
  int   v_start = 0;
  int   v_time = 0;
  int   n_rsp = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (!$onehot0(gnt) || !$onehot0(rsp_valid)) v_oh++;
    if ((|gnt) && (|rsp_valid)) v_oh++;
    if (mul_start != (|gnt)) v_start++;
    if ((|rsp_valid) && !rsp_err && !done_prev) v_time++;
    if (|rsp_valid) n_rsp++;
    done_prev = mul_done;
  end

  task automatic set_op(input int k, input logic [15:0] a,
                        input logic [15:0] b);
    in1_bus[k*WL +: WL] = a;
    in2_bus[k*WL +: WL] = b;
  endtask

  task automatic wait_gnt(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    chk(tag, 64'(gnt), 64'(exp));
  endtask

  task automatic wait_rsp(input string tag, input logic [3:0] ev,
                          input logic [15:0] ed, input logic ee);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
    end
    chk({tag, "_v"}, 64'(rsp_valid), 64'(ev));
    chk({tag, "_d"}, 64'(rsp_data), 64'(ed));
    chk({tag, "_e"}, 64'(rsp_err), 64'(ee));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'h0);
    chk({tag, "_rv"}, 64'(rsp_valid), 64'h0);
    chk({tag, "_out"},
        64'({rsp_data, rsp_err, busy, mul_start}), 64'h0);
    chk({tag, "_ops"}, 64'({mul_in1, mul_in2}), 64'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int n_snap;
  int n_cyc;

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    in1_bus   = '0;
    in2_bus   = '0;
    mul_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 0.5 x 0.5, one-cycle grant latency.
    set_op(0, Q_HALF, Q_HALF);
    req[0] = 1'b1;
    @(negedge clk);
    chk("t1_gnt_lat", 64'(gnt), 64'h1);
    chk("t1_ops", 64'({mul_in1, mul_in2}), 64'h20002000);
    req[0] = 1'b0;
    wait_rsp("t1", 4'b0001, 16'h1000, 1'b0);
    @(negedge clk);
    chk("t1_busy", 64'(busy), 64'h0);

    // All four at once after reset: order 0,1,2,3.
    do_reset();
    set_op(0, 16'h2000, 16'h4000);
    set_op(1, 16'h2000, 16'h2000);
    set_op(2, 16'h2000, 16'h1000);
    set_op(3, 16'h2000, 16'hE000);
    req = 4'b1111;
    wait_gnt("t2_g0", 4'b0001); req[0] = 1'b0;
    wait_rsp("t2_r0", 4'b0001, 16'h2000, 1'b0);
    wait_gnt("t2_g1", 4'b0010); req[1] = 1'b0;
    wait_rsp("t2_r1", 4'b0010, 16'h1000, 1'b0);
    wait_gnt("t2_g2", 4'b0100); req[2] = 1'b0;
    wait_rsp("t2_r2", 4'b0100, 16'h0800, 1'b0);
    wait_gnt("t2_g3", 4'b1000); req[3] = 1'b0;
    wait_rsp("t2_r3", 4'b1000, 16'hF000, 1'b0);

    // Serve 2, then 1 and 3 together: pointer at 3 wins.
    set_op(2, 16'h1000, 16'h2000);
    req[2] = 1'b1;
    wait_gnt("t3_g2", 4'b0100); req[2] = 1'b0;
    wait_rsp("t3_r2", 4'b0100, 16'h0800, 1'b0);
    set_op(1, 16'h2000, 16'h4000);
    set_op(3, 16'hE000, 16'h2000);
    req = 4'b1010;
    wait_gnt("t3_g3", 4'b1000); req[3] = 1'b0;
    wait_rsp("t3_neg", 4'b1000, 16'hF000, 1'b0);
    wait_gnt("t3_g1", 4'b0010); req[1] = 1'b0;
    wait_rsp("t3_r1", 4'b0010, 16'h2000, 1'b0);

    // Reset pulse while waiting on the multiplier.
    set_op(0, 16'h4000, 16'h4000);
    req[0] = 1'b1;
    wait_gnt("t5_g0", 4'b0001); req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_busy_wait", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    n_snap = n_rsp;
    repeat (20) @(negedge clk);
    chk("t5_no_rsp", 64'(n_rsp), 64'(n_snap));
    set_op(1, 16'h1000, 16'h1000);
    req[1] = 1'b1;
    wait_gnt("t5_g1", 4'b0010); req[1] = 1'b0;
    wait_rsp("t5_r1", 4'b0010, 16'h0400, 1'b0);

    // Multiplier that never completes on its own.
    set_op(2, 16'h3000, 16'h2000);
    mul_stall = 1'b1;
    req[2] = 1'b1;
    wait_gnt("t6_g2", 4'b0100); req[2] = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    n_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_cyc++;
      if (rsp_valid != '0) break;
    end
    chk("t6_tmo_cyc", 64'(n_cyc), 64'(TMO + 1));
    chk("t6_tmo_v", 64'(rsp_valid), 64'h4);
    chk("t6_tmo_e", 64'(rsp_err), 64'h1);
    chk("t6_tmo_d", 64'(rsp_data), 64'h0);
    n_snap = n_rsp;
    repeat (3) @(negedge clk);
    mul_stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_late_done", 64'(n_rsp), 64'(n_snap));
    chk("t6_idle", 64'(busy), 64'h0);
`else
    n_snap = n_rsp;
    n_cyc  = 0;
    repeat (100) @(negedge clk);
    chk("t6_no_rsp", 64'(n_rsp), 64'(n_snap));
    chk("t6_busy", 64'(busy), 64'h1);
    mul_stall = 1'b0;
    wait_rsp("t6_r2", 4'b0100, 16'h1800, 1'b0);
`endif

    chk("mon_onehot", 64'(v_oh), 64'h0);
    chk("mon_start", 64'(v_start), 64'h0);
    chk("mon_timing", 64'(v_time), 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
